ext_obi_dma: RTL and testbench

- Single-channel word-copy DMA engine that drives one `ext_xbar_master_req_i`/`ext_xbar_master_resp_o` port of the MCU system bus.
- Software configures it through the external peripheral register port (`ext_peripheral_slave_req_o`/`ext_peripheral_slave_resp_i`).
- Copies `LEN` bytes, word by word, from `SRC` to `DST` with one outstanding OBI transaction at a time.
- Raises a level interrupt on completion, wired to one bit of `intr_vector_ext_i`.

---
 rtl/ext_obi_dma.sv | 242 ++++++++++++++++++++++++
 tb/tb_ext_obi_dma.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_obi_dma.sv
// ext_obi_dma: single-channel word-copy DMA with a register slave port and one OBI master port.
// Optional: define EXT_OBI_DMA_ABORT_EN to enable CTRL.ABORT / STATUS.ABORTED.

package ext_obi_dma_pkg;
   typedef struct packed {
      logic        valid;
      logic        write;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

module ext_obi_dma
   import ext_obi_dma_pkg::*;
#(
   parameter int unsigned ADDR_OFFSET_W = 5,
   parameter int unsigned LEN_W         = 16
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  reg_req_t  reg_req_i,
   output reg_rsp_t  reg_rsp_o,
   output obi_req_t  master_req_o,
   input  obi_resp_t master_resp_i,
   output logic      irq_o
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH} state_e;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      return r;
   endfunction

   state_e           state_q;
   logic [31:0]      src_q, src_d, dst_q, dst_d;
   logic [LEN_W-1:0] len_q, len_d, rem_q;
   logic             irq_en_q, irq_en_d, done_q, done_d, irq_q;
   logic [31:0]      wsrc_q, wdst_q, hold_q, addr_q;
   logic             req_q, we_q;
   logic [3:0]       be_q;

   logic [ADDR_OFFSET_W-1:0] off;
   logic [2:0]       widx;
   logic             off_err, wr_en, busy, ctrl_wr, stat_wr, start;
   logic             abort_now, aborted_rd;
   logic             unused_addr;

   assign off         = reg_req_i.addr[ADDR_OFFSET_W-1:0];
   assign widx        = off[4:2];
   assign off_err     = 32'(off) > 32'h10;
   assign wr_en       = reg_req_i.valid & reg_req_i.write & ~off_err;
   assign busy        = (state_q != IDLE);
   assign ctrl_wr     = wr_en & (widx == 3'd3) & reg_req_i.wstrb[0];
   assign stat_wr     = wr_en & (widx == 3'd4) & reg_req_i.wstrb[0];
   assign start       = ctrl_wr & reg_req_i.wdata[0] & ~busy;
   assign unused_addr = ^reg_req_i.addr[31:ADDR_OFFSET_W];

`ifdef EXT_OBI_DMA_ABORT_EN
   logic abort_q, aborted_q, abort_wr;

   assign abort_wr   = ctrl_wr & reg_req_i.wdata[2] & busy;
   assign abort_now  = abort_q | abort_wr;
   assign aborted_rd = aborted_q;

   // Abort request is held until the FSM reaches a word boundary and passes through FINISH.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         abort_q   <= 1'b0;
         aborted_q <= 1'b0;
      end else if (state_q == FINISH) begin
         abort_q   <= 1'b0;
         aborted_q <= abort_q | abort_wr;
      end else begin
         if (abort_wr) abort_q <= 1'b1;
         if (start)    aborted_q <= 1'b0;
      end
   end
`else
   assign abort_now  = 1'b0;
   assign aborted_rd = 1'b0;
`endif

   always_comb begin
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      if (wr_en && !busy && widx == 3'd0)
         src_d = apply_strb(src_q, reg_req_i.wdata, reg_req_i.wstrb);
      if (wr_en && !busy && widx == 3'd1)
         dst_d = apply_strb(dst_q, reg_req_i.wdata, reg_req_i.wstrb);
      if (wr_en && !busy && widx == 3'd2) begin
         len_d      = LEN_W'(apply_strb(32'(len_q), reg_req_i.wdata, reg_req_i.wstrb));
         len_d[1:0] = 2'b00;
      end
      if (ctrl_wr)
         irq_en_d = reg_req_i.wdata[1];
      if (stat_wr && reg_req_i.wdata[1])
         done_d = 1'b0;
      // Completion outranks a same-cycle software clear.
      if (state_q == FINISH)
         done_d = 1'b1;
   end

   always_comb begin
      reg_rsp_o       = '0;
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.error = reg_req_i.valid & off_err;
      if (!off_err) begin
         case (widx)
            3'd0:    reg_rsp_o.rdata = src_q;
            3'd1:    reg_rsp_o.rdata = dst_q;
            3'd2:    reg_rsp_o.rdata = 32'(len_q);
            3'd3:    reg_rsp_o.rdata = {30'b0, irq_en_q, 1'b0};
            3'd4:    reg_rsp_o.rdata = {29'b0, aborted_rd, done_q, busy};
            default: reg_rsp_o.rdata = '0;
         endcase
      end
   end

   assign master_req_o = '{req: req_q, we: we_q, be: be_q, addr: addr_q, wdata: hold_q};
   assign irq_o        = irq_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         irq_q    <= 1'b0;
         wsrc_q   <= '0;
         wdst_q   <= '0;
         rem_q    <= '0;
         hold_q   <= '0;
         addr_q   <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= '0;
      end else begin
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         irq_q    <= done_q & irq_en_q;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (len_q != '0) begin
                     wsrc_q  <= src_q;
                     wdst_q  <= dst_q;
                     rem_q   <= len_q;
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                     be_q    <= 4'hF;
                     addr_q  <= src_q & 32'hFFFF_FFFC;
                     state_q <= RD_REQ;
                  end else begin
                     state_q <= FINISH;
                  end
               end
            end
            // Request fields are frozen until the grant is seen.
            RD_REQ: begin
               if (master_resp_i.gnt) begin
                  req_q   <= 1'b0;
                  state_q <= RD_WAIT;
               end else if (abort_now) begin
                  req_q   <= 1'b0;
                  state_q <= FINISH;
               end
            end
            RD_WAIT: begin
               if (master_resp_i.rvalid) begin
                  hold_q <= master_resp_i.rdata;
                  if (abort_now) begin
                     state_q <= FINISH;
                  end else begin
                     req_q   <= 1'b1;
                     we_q    <= 1'b1;
                     addr_q  <= wdst_q & 32'hFFFF_FFFC;
                     state_q <= WR_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (master_resp_i.gnt) begin
                  req_q   <= 1'b0;
                  state_q <= WR_WAIT;
               end
            end
            WR_WAIT: begin
               if (master_resp_i.rvalid) begin
                  wsrc_q <= wsrc_q + 32'd4;
                  wdst_q <= wdst_q + 32'd4;
                  rem_q  <= rem_q - LEN_W'(4);
                  if (rem_q == LEN_W'(4) || abort_now) begin
                     state_q <= FINISH;
                  end else begin
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                     addr_q  <= (wsrc_q + 32'd4) & 32'hFFFF_FFFC;
                     state_q <= RD_REQ;
                  end
               end
            end
            FINISH:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ext_obi_dma.sv
// Directed self-checking bench for ext_obi_dma with a small OBI memory model.
module tb_ext_obi_dma;
   import ext_obi_dma_pkg::*;

   localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_LEN = 32'h08;
   localparam logic [31:0] A_CTRL = 32'h0C, A_STAT = 32'h10;

   logic      clk = 1'b0;
   logic      rst;
   reg_req_t  reg_req;
   reg_rsp_t  reg_rsp;
   obi_req_t  mreq;
   obi_resp_t mresp;
   logic      irq;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem [logic [31:0]];
   bit          model_en = 1'b1;
   int          gnt_delay = 0;
   int          wait_cnt = 0;
   logic        mdl_gnt = 1'b0, mdl_rvalid = 1'b0;
   logic [31:0] mdl_rdata = '0;
   logic        man_gnt = 1'b0, man_rvalid = 1'b0;
   logic [31:0] man_rdata = '0;
   obi_req_t    snap;
   int          n_req_cyc = 0, n_wr = 0;
   logic [31:0] log_addr[$];
   logic        log_we[$];

   logic [31:0] exp_a [6];
   logic        exp_we[6];
   logic [31:0] d, st;
   logic        e;
   int          base;
   bit          fin;

   always #5 clk = ~clk;

   assign mresp = model_en ? obi_resp_t'{gnt: mdl_gnt, rvalid: mdl_rvalid, rdata: mdl_rdata}
                           : obi_resp_t'{gnt: man_gnt, rvalid: man_rvalid, rdata: man_rdata};

   ext_obi_dma dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .reg_req_i    (reg_req),
      .reg_rsp_o    (reg_rsp),
      .master_req_o (mreq),
      .master_resp_i(mresp),
      .irq_o        (irq)
   );

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory model: grants after gnt_delay waiting cycles, returns rvalid the cycle after gnt.
   always @(negedge clk) begin
      if (!model_en || rst) begin
         mdl_gnt    = 1'b0;
         mdl_rvalid = 1'b0;
         wait_cnt   = 0;
      end else begin
         mdl_rvalid = 1'b0;
         if (mreq.req) n_req_cyc++;
         if (mdl_gnt) begin
            mdl_gnt = 1'b0;
            log_addr.push_back(snap.addr);
            log_we.push_back(snap.we);
            if (snap.we) begin
               mem[snap.addr] = snap.wdata;
               n_wr++;
            end else begin
               mdl_rdata = mem.exists(snap.addr) ? mem[snap.addr] : ~snap.addr;
            end
            mdl_rvalid = 1'b1;
         end else if (mreq.req) begin
            if (wait_cnt == 0) snap = mreq;
            else chk("req_stable", mreq, snap);
            if (wait_cnt == gnt_delay) begin
               mdl_gnt  = 1'b1;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   task automatic reg_wr(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                         output logic err);
      reg_req = '{valid: 1'b1, write: 1'b1, wstrb: s, addr: a, wdata: dat};
      #1 err = reg_rsp.error;
      @(posedge clk);
      #1 reg_req = '0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] dat);
      logic err;
      reg_wr(a, dat, 4'hF, err);
   endtask

   task automatic reg_rd(input logic [31:0] a, output logic [31:0] dat, output logic err);
      reg_req = '{valid: 1'b1, write: 1'b0, wstrb: 4'h0, addr: a, wdata: 32'h0};
      #1;
      dat = reg_rsp.rdata;
      err = reg_rsp.error;
      reg_req = '0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] v;
      logic        err;
      reg_rd(a, v, err);
      chk(tag, v, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst     = 1'b1;
      reg_req = '0;
      exp_a   = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008};
      exp_we  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      mem[32'h1000] = 32'hA5A5_0001;
      mem[32'h1004] = 32'h5A5A_0002;
      mem[32'h1008] = 32'hCAFE_0003;
      mem[32'h3000] = 32'h1357_9BDF;
      mem[32'h3004] = 32'h2468_ACE0;

      #1;
      chk("rst_req", mreq, '0);
      chk("rst_irq", irq, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rd_chk("rst_src", A_SRC, 0);
      rd_chk("rst_dst", A_DST, 0);
      rd_chk("rst_len", A_LEN, 0);
      rd_chk("rst_ctrl", A_CTRL, 0);
      rd_chk("rst_stat", A_STAT, 0);
      @(posedge clk);
      #1;

      // Basic 3-word copy with cycle-exact completion.
      wr(A_SRC, 32'h1000);
      wr(A_DST, 32'h2000);
      wr(A_LEN, 32'd12);
      wr(A_CTRL, 32'h2);
      wr(A_CTRL, 32'h3);
      repeat (12) @(posedge clk);
      #1 rd_chk("t1_busy_e12", A_STAT, 32'h1);
      @(posedge clk);
      #1 rd_chk("t1_done_e13", A_STAT, 32'h2);
      chk("t1_irq_e13", irq, 0);
      @(posedge clk);
      #1 chk("t1_irq_e14", irq, 1);
      chk("t1_nlog", log_addr.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t1_addr%0d", i), log_addr[i], exp_a[i]);
         chk($sformatf("t1_we%0d", i), log_we[i], exp_we[i]);
      end
      chk("t1_mem0", mem[32'h2000], 32'hA5A5_0001);
      chk("t1_mem1", mem[32'h2004], 32'h5A5A_0002);
      chk("t1_mem2", mem[32'h2008], 32'hCAFE_0003);
      wr(A_STAT, 32'h2);
      @(posedge clk);
      #1 chk("t1_irq_clr", irq, 0);
      rd_chk("t1_stat_clr", A_STAT, 32'h0);

      // Zero-length start: no bus traffic.
      log_addr.delete();
      log_we.delete();
      base = n_req_cyc;
      wr(A_LEN, 32'd0);
      wr(A_CTRL, 32'h3);
      @(posedge clk);
      #1 rd_chk("t2_done", A_STAT, 32'h2);
      rd_chk("t2_ctrl_start_rd0", A_CTRL, 32'h2);
      repeat (3) @(posedge clk);
      #1 chk("t2_no_req", n_req_cyc - base, 0);
      chk("t2_no_log", log_addr.size(), 0);
      wr(A_STAT, 32'h2);

      // Register boundaries: LEN alignment/width, byte strobes.
      wr(A_LEN, 32'h0000_1237);
      rd_chk("len_align", A_LEN, 32'h1234);
      wr(A_LEN, 32'hFFFF_FFFF);
      rd_chk("len_width", A_LEN, 32'hFFFC);
      wr(A_SRC, 32'h0);
      reg_wr(A_SRC, 32'hFFFF_FFFF, 4'b0101, e);
      rd_chk("src_wstrb", A_SRC, 32'h00FF_00FF);

      // Delayed grants, unaligned SRC, writes while busy.
      log_addr.delete();
      log_we.delete();
      gnt_delay = 5;
      wr(A_SRC, 32'h0000_3003);
      wr(A_DST, 32'h4000);
      wr(A_LEN, 32'd8);
      wr(A_CTRL, 32'h3);
      reg_wr(A_SRC, 32'hDEAD_0000, 4'hF, e);
      chk("t4_busy_wr_err", e, 0);
      rd_chk("t4_src_kept", A_SRC, 32'h0000_3003);
      reg_rd(32'h14, d, e);
      chk("t4_bad_rdata", d, 0);
      chk("t4_bad_err", e, 1);
      fin = 1'b0;
      st  = '0;
      for (int i = 0; i < 300 && !fin; i++) begin
         @(posedge clk);
         #1 reg_rd(A_STAT, st, e);
         fin = st[1];
      end
      chk("t3_done", st, 32'h2);
      chk("t3_rd0_addr", log_addr[0], 32'h3000);
      chk("t3_wr0_addr", log_addr[1], 32'h4000);
      chk("t3_rd1_addr", log_addr[2], 32'h3004);
      chk("t3_mem0", mem[32'h4000], 32'h1357_9BDF);
      chk("t3_mem1", mem[32'h4004], 32'h2468_ACE0);
      gnt_delay = 0;
      @(posedge clk);
      #1 wr(A_STAT, 32'h2);

`ifdef EXT_OBI_DMA_ABORT_EN
      // Abort during the second word's write response.
      base = n_wr;
      wr(A_SRC, 32'h7000);
      wr(A_DST, 32'h8000);
      wr(A_LEN, 32'd64);
      wr(A_CTRL, 32'h3);
      repeat (7) @(posedge clk);
      #1 wr(A_CTRL, 32'h6);
      @(posedge clk);
      #1 rd_chk("ab_status", A_STAT, 32'h6);
      chk("ab_nwr", n_wr - base, 2);
      chk("ab_mem1", mem[32'h8004], ~32'h7004);
      chk("ab_no_third", mem.exists(32'h8008), 0);
      rd_chk("ab_len_kept", A_LEN, 32'd64);
      rd_chk("ab_src_kept", A_SRC, 32'h7000);
      wr(A_LEN, 32'd0);
      wr(A_CTRL, 32'h1);
      @(posedge clk);
      #1 rd_chk("ab_clr_by_start", A_STAT, 32'h2);
      wr(A_STAT, 32'h2);
`else
      wr(A_CTRL, 32'h6);
      rd_chk("noab_ctrl", A_CTRL, 32'h2);
      rd_chk("noab_stat", A_STAT, 32'h0);
`endif

      // Reset during WR_WAIT with a late response afterwards.
      model_en = 1'b0;
      wr(A_SRC, 32'h5000);
      wr(A_DST, 32'h6000);
      wr(A_LEN, 32'd4);
      wr(A_CTRL, 32'h3);
      man_gnt = 1'b1;
      @(posedge clk);
      #1 man_gnt = 1'b0;
      man_rvalid = 1'b1;
      man_rdata  = 32'h0000_0077;
      @(posedge clk);
      #1 man_rvalid = 1'b0;
      chk("rs_wr_req", mreq, {1'b1, 1'b1, 4'hF, 32'h6000, 32'h77});
      man_gnt = 1'b1;
      @(posedge clk);
      #1 man_gnt = 1'b0;
      chk("rs_wait_req", mreq.req, 0);
      #2 rst = 1'b1;
      #1 chk("rs_async_req", mreq, '0);
      @(posedge clk);
      #1 rst = 1'b0;
      man_rvalid = 1'b1;
      @(posedge clk);
      #1 man_rvalid = 1'b0;
      @(posedge clk);
      #1 rd_chk("rs_stat", A_STAT, 0);
      rd_chk("rs_src", A_SRC, 0);
      rd_chk("rs_dst", A_DST, 0);
      rd_chk("rs_len", A_LEN, 0);
      rd_chk("rs_ctrl", A_CTRL, 0);
      chk("rs_req_after", mreq, '0);
      chk("rs_irq", irq, 0);
      model_en = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
